cmd_mem_burst: RTL and testbench
================================

Name: cmd_mem_burst

Overview:
Parametrised command memory with a burst fetch engine and a run-time load port.
- A fetch request names a start address and a word count. The block streams that many commands out through a valid/ready handshake, wrapping at the top of memory.
- The load port lets the host or loader write commands at any time.
- It sits between the control unit's fetch stage and the command store, replacing the single-word, fixed-content command memory.

Parameters:
CMD_W, 16, command word width in bits
DEPTH, 16, number of command words (need not be a power of two, minimum 2)
ADR_W, $clog2(DEPTH), address width (derived; do not override)
LEN_W, 8, burst length field width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  1  fetch request; sampled only in IDLE
req_adr  in  ADR_W  burst start address
req_len  in  LEN_W  number of words to fetch
busy  out  1  high while a burst is in progress
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse when a request is rejected
cmd  out  CMD_W  command word
cmd_valid  out  1  cmd holds a valid word
cmd_ready  in  1  consumer accepts cmd
wr_en  in  1  memory write enable
wr_adr  in  ADR_W  write address
wr_data  in  CMD_W  write data

Behaviour:
- Reset (async assert, sync release):
  - Outputs: busy=0, done=0, err=0, cmd=0, cmd_valid=0.
  - FSM goes to IDLE; burst pointer and remaining count cleared.
  - Memory contents are NOT cleared. Simulation power-up contents are zero.
- FSM states: IDLE, STREAM.
- IDLE, req=1 at edge E0:
  - req_adr>=DEPTH: request rejected, err=1 for the cycle after E0, FSM stays IDLE.
  - req_len=0: done=1 for the cycle after E0, no cmd_valid, FSM stays IDLE.
  - Otherwise: at E0 latch ptr=req_adr and rem=req_len, go to STREAM, busy=1. At E1, cmd=mem[req_adr] and cmd_valid=1. Read latency is one clock.
- STREAM, handshake (cmd_valid & cmd_ready at an edge):
  - rem>1: at that same edge, ptr advances, rem decrements, and cmd loads mem[next ptr]. cmd_valid stays 1, giving a throughput of one word per clock.
  - rem==1: cmd_valid=0, done=1 for one cycle, busy=0, FSM returns to IDLE. cmd keeps its last value.
- Backpressure: while cmd_valid=1 and cmd_ready=0, cmd, ptr and rem hold stable. There is no timeout.
- Wrap-around: ptr==DEPTH-1 advances to 0. A burst with req_len>DEPTH wraps as many times as needed.
- Requests during STREAM are ignored; there is no queueing and err is not raised. A new request is accepted at the earliest one cycle after the done edge.
- Load port:
  - The write takes effect at the edge where wr_en=1, in any state.
  - Collision rule (read-before-write): if cmd loads from the same address at the same edge, cmd gets the OLD word. A subsequent read returns the new word.
  - wr_adr>=DEPTH: the write is dropped silently.
- done and err are never high together.
- Reset mid-burst aborts immediately: cmd_valid=0, no done pulse.

Decomposition:
- Package cmd_mem_pkg:
  - state enum (IDLE, STREAM)
  - default CMD_W/DEPTH/LEN_W constants
  - CMD_NOP constant (all zeros)
- Sub-module cmd_ram:
  - simple dual-port: one sync read port with read enable, one write port
  - read-before-write, no reset on the array
  - parameters CMD_W, DEPTH
- cmd_mem_burst contains the FSM, ptr/rem counters, output register control and range checks.

Test Plan:
1. Load addresses 0..15 with 16'h1000+i via the write port. req adr=3 len=4, cmd_ready=1 -> cmd 1003,1004,1005,1006 on four consecutive cycles starting one cycle after req. done pulses with the last handshake; busy is high for exactly 4 cycles.
2. req adr=14 len=4 with cmd_ready toggling 1,0,1,0,...:
   - cmd sequence 100E,100F,1000,1001 (wrap).
   - Each word is held stable during ready=0.
   - done occurs after the 4th handshake.
3. DEPTH=12 build: req adr=12 -> err pulse one cycle later, busy stays 0, no cmd_valid. Then req len=0 -> done pulse, no cmd_valid.
4. During a burst, write 16'hBEEF to the address being loaded at that edge -> cmd shows the old word. Re-fetch of that address -> BEEF. A req asserted mid-burst is ignored, with no err.
5. Assert rst asynchronously mid-burst with cmd_valid=1 -> cmd_valid, busy, cmd drop to 0 without waiting for a clock; no done. After release, a fetch returns the pre-reset memory contents unchanged.

Source files
------------

// File: rtl/cmd_mem_pkg.sv
// Shared types and defaults for the burst command memory.
package cmd_mem_pkg;

  // Fetch engine states
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Default build parameters
  localparam int CMD_W_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam int LEN_W_DEF = 8;

  // Command word presented on cmd while nothing has been fetched
  localparam logic [CMD_W_DEF-1:0] CMD_NOP = '0;

endpackage

// File: rtl/cmd_ram.sv
// Simple dual-port command store: one registered read port with enable,
// one write port. Read-before-write on an address collision.
module cmd_ram
  import cmd_mem_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [ADR_W-1:0] rd_adr_i,
  output logic [CMD_W-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [ADR_W-1:0] wr_adr_i,
  input  logic [CMD_W-1:0] wr_data_i
);

  localparam logic [ADR_W:0] DEPTH_L = (ADR_W + 1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] rd_data_q;
  logic             wr_ok;

  // Writes beyond the last word are dropped
  assign wr_ok = wr_en_i && ({1'b0, wr_adr_i} < DEPTH_L);

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_adr_i] <= wr_data_i;
    end
  end

  // Registered read; a same-edge write is not visible until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= CMD_W'(CMD_NOP);
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_adr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cmd_mem_burst.sv
// Burst fetch engine in front of a loadable command store. A request names
// a start address and a length; words stream out over valid/ready and the
// address wraps at the top of memory.
module cmd_mem_burst
  import cmd_mem_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADR_W = $clog2(DEPTH),
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  input  logic             wr_en,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [CMD_W-1:0] wr_data
);

  localparam logic [ADR_W:0] DEPTH_L = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W-1:0] TOP_ADR = ADR_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             rd_en;
  logic [ADR_W-1:0] rd_adr;
  logic [ADR_W-1:0] ptr_nxt;
  logic             adr_ok;
  logic             hs;
  logic             last_word;

  assign adr_ok    = ({1'b0, req_adr} < DEPTH_L);
  assign hs        = valid_q & cmd_ready;
  assign last_word = (rem_q <= LEN_W'(1));
  assign ptr_nxt   = (ptr_q == TOP_ADR) ? '0 : ptr_q + 1'b1;

  // State, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // Next state and burst pointer/count bookkeeping
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (req && adr_ok && (req_len != '0)) begin
          state_d = STREAM;
          ptr_d   = req_adr;
          rem_d   = req_len;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!last_word) begin
            ptr_d = ptr_nxt;
            rem_d = rem_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status pulses, valid flag and read-port control
  always_comb begin
    done_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = valid_q;
    rd_en   = 1'b0;
    rd_adr  = ptr_nxt;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (req) begin
          if (!adr_ok) begin
            err_d = 1'b1;
          end else if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            rd_en   = 1'b1;
            rd_adr  = req_adr;
          end
        end
      end
      STREAM: begin
        if (hs) begin
          if (!last_word) begin
            rd_en = 1'b1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  cmd_ram #(
    .CMD_W(CMD_W),
    .DEPTH(DEPTH),
    .ADR_W(ADR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_en_i  (rd_en),
    .rd_adr_i (rd_adr),
    .rd_data_o(cmd),
    .wr_en_i  (wr_en),
    .wr_adr_i (wr_adr),
    .wr_data_i(wr_data)
  );

  assign busy      = (state_q == STREAM);
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_valid = valid_q;

endmodule

// File: tb/tb_cmd_mem_burst.sv
// Bench for cmd_mem_burst: a DEPTH=16 instance checked through a word
// scoreboard, plus a DEPTH=12 instance sharing the same inputs.
module tb_cmd_mem_burst;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  req_adr;
  logic [7:0]  req_len;
  logic        cmd_ready;
  logic        wr_en;
  logic [3:0]  wr_adr;
  logic [15:0] wr_data;

  logic        busy, done, err, cmd_valid;
  logic [15:0] cmd;
  logic        busy12, done12, err12, cmd_valid12;
  logic [15:0] cmd12;

  cmd_mem_burst dut (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_len(req_len),
    .busy(busy), .done(done), .err(err), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data)
  );

  cmd_mem_burst #(.DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_len(req_len),
    .busy(busy12), .done(done12), .err(err12), .cmd(cmd12), .cmd_valid(cmd_valid12),
    .cmd_ready(cmd_ready), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q [$];
  logic [15:0] last_word = '0;

  typedef struct {
    int          adr;
    int          len;
    int          mode;      // 0: ready always high, 1: ready toggles 1,0,1,0
    int          exp_busy;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int adr, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(adr + i) % DEPTH]);
  endtask

  // Scoreboard: pop on every handshake, check the held word under backpressure
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%h expected=none", cmd);
        end else begin
          check("stream_word", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
          last_word = cmd;
        end
      end else if (exp_q.size() != 0) begin
        check("hold_word", {16'h0, cmd}, {16'h0, exp_q[0]});
      end
    end
  end

  task automatic run_burst(input int adr, input int len, input int mode,
                           output int busy_cyc, output int done_seen,
                           output int err_seen, output int valid_at_done);
    push_exp(adr, len);
    @(posedge clk); #1;
    req = 1'b1; req_adr = adr[3:0]; req_len = len[7:0]; cmd_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    busy_cyc = 0; done_seen = 0; err_seen = 0; valid_at_done = 0;
    for (int c = 0; c < 300 && done_seen == 0; c++) begin
      @(negedge clk); #1;
      if (err) err_seen++;
      if (done) begin
        done_seen = 1;
        valid_at_done = int'(cmd_valid) + int'(busy);
      end else if (busy) begin
        busy_cyc++;
      end
      @(posedge clk); #1;
      if (done_seen == 0) cmd_ready = (mode == 1) ? ~cmd_ready : 1'b1;
    end
    cmd_ready = 1'b1;
  endtask

  initial begin
    int          bc, ds, es, vd, got, errs;
    logic [15:0] w12 [3];

    vecs[0] = '{adr: 3,  len: 4,  mode: 0, exp_busy: 4,  exp_last: 16'h1006};
    vecs[1] = '{adr: 14, len: 4,  mode: 1, exp_busy: 7,  exp_last: 16'h1001};
    vecs[2] = '{adr: 15, len: 1,  mode: 0, exp_busy: 1,  exp_last: 16'h100F};
    vecs[3] = '{adr: 10, len: 20, mode: 0, exp_busy: 20, exp_last: 16'h100D};
    vecs[4] = '{adr: 0,  len: 16, mode: 1, exp_busy: 31, exp_last: 16'h100F};
    w12[0] = 16'h100A; w12[1] = 16'h100B; w12[2] = 16'h1000;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    rst = 1'b1; req = 1'b0; req_adr = '0; req_len = '0; cmd_ready = 1'b0;
    wr_en = 1'b0; wr_adr = '0; wr_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd", cmd, 0);
    check("rst_valid", cmd_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load 0..15 with 1000+i
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_adr = i[3:0]; wr_data = 16'h1000 + i[15:0];
      model_mem[i] = 16'h1000 + i[15:0];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    $display("load 16 words done");

    // Table-driven bursts
    for (int k = 0; k < 5; k++) begin
      run_burst(vecs[k].adr, vecs[k].len, vecs[k].mode, bc, ds, es, vd);
      check("busy_cycles", bc, vecs[k].exp_busy);
      check("done_pulse", ds, 1);
      check("no_err", es, 0);
      check("idle_at_done", vd, 0);
      check("last_word", {16'h0, last_word}, {16'h0, vecs[k].exp_last});
      check("queue_drained", exp_q.size(), 0);
      $display("burst adr=%0d len=%0d mode=%0d busy=%0d last=%h", vecs[k].adr, vecs[k].len,
               vecs[k].mode, bc, last_word);
    end

    // DEPTH=12 instance: out-of-range request, zero length, wrap at 11
    push_exp(12, 2);
    @(posedge clk); #1;
    req = 1'b1; req_adr = 4'd12; req_len = 8'd2; cmd_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("d12_err_pulse", err12, 1);
    check("d12_err_busy", busy12, 0);
    check("d12_err_valid", cmd_valid12, 0);
    check("d12_err_done", done12, 0);
    check("d16_adr12_no_err", err, 0);
    @(negedge clk);
    check("d12_err_one_cycle", err12, 0);
    repeat (3) @(posedge clk); #1;
    req = 1'b1; req_adr = 4'd0; req_len = 8'd0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("len0_done12", done12, 1);
    check("len0_valid12", cmd_valid12, 0);
    check("len0_err12", err12, 0);
    check("len0_busy12", busy12, 0);
    check("len0_done", done, 1);
    check("len0_valid", cmd_valid, 0);
    @(negedge clk);
    check("len0_done_one_cycle", done12, 0);
    $display("depth12 reject and zero-length requests done");
    push_exp(10, 3);
    @(posedge clk); #1;
    req = 1'b1; req_adr = 4'd10; req_len = 8'd3;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d12_wrap_word", {16'h0, cmd12}, {16'h0, w12[k]});
      check("d12_wrap_valid", cmd_valid12, 1);
    end
    @(negedge clk);
    check("d12_wrap_done", done12, 1);
    $display("depth12 wrap burst adr=10 len=3 done");
    @(posedge clk); #1;

    // Collision: write BEEF to the address loaded at the same edge
    push_exp(0, 4);
    @(posedge clk); #1;
    req = 1'b1; req_adr = 4'd0; req_len = 8'd4; cmd_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_adr = 4'd2; wr_data = 16'hBEEF;
    req = 1'b1; req_adr = 4'd5; req_len = 8'd1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_mem[2] = 16'hBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    got = 0; errs = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk); #1;
      if (err) errs++;
      if (done) got = 1;
    end
    check("collision_done", got, 1);
    check("midburst_req_no_err", errs, 0);
    check("collision_queue", exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midburst_req_ignored_busy", busy, 0);
    check("midburst_req_ignored_valid", cmd_valid, 0);
    $display("collision burst adr=0 len=4 with write adr=2 done");
    run_burst(2, 1, 0, bc, ds, es, vd);
    check("refetch_done", ds, 1);
    check("refetch_word", {16'h0, last_word}, 32'h0000BEEF);
    $display("refetch adr=2 len=1 word=%h", last_word);

    // Asynchronous reset mid-burst under backpressure
    @(posedge clk); #1;
    req = 1'b1; req_adr = 4'd5; req_len = 8'd8; cmd_ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", cmd_valid, 1);
    check("pre_rst_word", {16'h0, cmd}, {16'h0, model_mem[5]});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", cmd_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd", cmd, 0);
    check("async_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_done", done, 0);
    check("post_rst_valid", cmd_valid, 0);
    $display("async reset mid-burst adr=5 len=8 done");
    run_burst(5, 2, 0, bc, ds, es, vd);
    check("post_rst_done", ds, 1);
    check("post_rst_busy", bc, 2);
    check("post_rst_last", {16'h0, last_word}, 32'h00001006);
    check("final_queue", exp_q.size(), 0);
    $display("post-reset burst adr=5 len=2 last=%h", last_word);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
